// File: rtl/dbns_mult_scheduler.sv
// Round-robin scheduler that time-shares one fixed-latency DBNS multiplier
// among four requesters, with one operation in flight at a time.
module dbns_mult_scheduler #(
  parameter int LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [63:0] op_a,
  input  logic [63:0] op_b,
  output logic [3:0]  grant,
  output logic [15:0] REGA,
  output logic [15:0] REGB,
  input  logic [31:0] REGC,
  output logic        rsp_valid,
  output logic [1:0]  rsp_id,
  output logic [31:0] rsp_data,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [3:0] LAST_CNT = 4'(LAT - 1);

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [1:0]  ptr_reg, ptr_next;
  logic [3:0]  grant_reg, grant_next;
  logic [15:0] rega_reg, rega_next;
  logic [15:0] regb_reg, regb_next;
  logic        rsp_valid_reg, rsp_valid_next;
  logic [1:0]  rsp_id_reg, rsp_id_next;
  logic [31:0] rsp_data_reg, rsp_data_next;

  logic [15:0] a_arr [4];
  logic [15:0] b_arr [4];
  logic [1:0]  win;
  logic [1:0]  idx;
  logic        found;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_unpack
      assign a_arr[gi] = op_a[16*gi +: 16];
      assign b_arr[gi] = op_b[16*gi +: 16];
    end
  endgenerate

  // Search starts at ptr and wraps, so the last winner is checked last.
  always_comb begin
    win   = ptr_reg;
    idx   = ptr_reg;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_reg + 2'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    ptr_next       = ptr_reg;
    grant_next     = 4'b0000;
    rega_next      = rega_reg;
    regb_next      = regb_reg;
    rsp_valid_next = 1'b0;
    rsp_id_next    = rsp_id_reg;
    rsp_data_next  = rsp_data_reg;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          grant_next  = 4'b0001 << win;
          rega_next   = a_arr[win];
          regb_next   = b_arr[win];
          rsp_id_next = win;
          ptr_next    = win + 2'd1;
          cnt_next    = 4'd0;
          state_next  = WAIT;
        end
      end
      WAIT: begin
        cnt_next = cnt_reg + 4'd1;
        if (cnt_reg == LAST_CNT) state_next = DONE;
      end
      DONE: begin
        rsp_data_next  = REGC;
        rsp_valid_next = 1'b1;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg       <= 4'd0;
      ptr_reg       <= 2'd0;
      grant_reg     <= 4'b0000;
      rega_reg      <= 16'd0;
      regb_reg      <= 16'd0;
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= 2'd0;
      rsp_data_reg  <= 32'd0;
    end else begin
      cnt_reg       <= cnt_next;
      ptr_reg       <= ptr_next;
      grant_reg     <= grant_next;
      rega_reg      <= rega_next;
      regb_reg      <= regb_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_id_reg    <= rsp_id_next;
      rsp_data_reg  <= rsp_data_next;
    end
  end

  assign grant     = grant_reg;
  assign REGA      = rega_reg;
  assign REGB      = regb_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_id    = rsp_id_reg;
  assign rsp_data  = rsp_data_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_dbns_mult_scheduler.sv
// Directed bench for dbns_mult_scheduler; a LAT-stage delay line stands in
// for the multiplier so an early sample of REGC returns a stale product.
module tb_dbns_mult_scheduler;

  localparam int LAT = 4;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [63:0] op_a;
  logic [63:0] op_b;
  logic [3:0]  grant;
  logic [15:0] REGA;
  logic [15:0] REGB;
  logic [31:0] REGC;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_data;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int gcount [4];

  logic [31:0] pipe [LAT];

  dbns_mult_scheduler #(.LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b),
    .grant(grant), .REGA(REGA), .REGB(REGB), .REGC(REGC),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    pipe[0] <= 32'(REGA) * 32'(REGB);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign REGC = pipe[LAT-1];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input int i, input logic [15:0] a, input logic [15:0] b);
    op_a[16*i +: 16] = a;
    op_b[16*i +: 16] = b;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_grant"}, 32'(grant), 32'd0);
    chk({tag, "_rega"}, 32'(REGA), 32'd0);
    chk({tag, "_regb"}, 32'(REGB), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
    chk({tag, "_rsp_data"}, rsp_data, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Caller drives req before the call; returns in the rsp_valid cycle.
  task automatic run_op(input string tag, input logic [3:0] exp_grant, input logic [1:0] exp_id,
                        input logic [31:0] exp_data, input logic [3:0] req_after,
                        input logic [3:0] req_mid);
    step();
    chk({tag, "_grant"}, 32'(grant), 32'(exp_grant));
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) if (grant[i]) gcount[i]++;
    req = req_after;
    for (int c = 1; c <= LAT; c++) begin
      if (c == 2) req = req_mid;
      step();
      chk($sformatf("%s_wait%0d_grant", tag, c), 32'(grant), 32'd0);
      chk($sformatf("%s_wait%0d_valid", tag, c), 32'(rsp_valid), 32'd0);
    end
    step();
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_rsp_id"}, 32'(rsp_id), 32'(exp_id));
    chk({tag, "_rsp_data"}, rsp_data, exp_data);
    chk({tag, "_rsp_grant"}, 32'(grant), 32'd0);
    chk({tag, "_rsp_busy"}, 32'(busy), 32'd0);
    $display("op %s: grant=%b id=%0d data=0x%08h", tag, grant == 4'b0 ? exp_grant : grant, rsp_id, rsp_data);
  endtask

  initial begin
    rst = 1'b1; req = 4'b0000; op_a = '0; op_b = '0;
    for (int i = 0; i < 4; i++) gcount[i] = 0;
    repeat (3) step();
    chk_zero("reset");

    // Single operation: 7890 * 7890
    set_ops(0, 16'd7890, 16'd7890);
    rst = 1'b0; req = 4'b0001;
    run_op("single", 4'b0001, 2'd0, 32'd62252100, 4'b0000, 4'b0000);
    step();
    chk("single_after_valid", 32'(rsp_valid), 32'd0);
    chk("single_hold_data", rsp_data, 32'd62252100);
    chk("single_idle_grant", 32'(grant), 32'd0);

    // Round robin with boundary operands; reset first so ptr is 0
    rst = 1'b1; step(); rst = 1'b0;
    chk("rr_reset_data", rsp_data, 32'd0);
    set_ops(0, 16'd3, 16'd5);
    set_ops(1, 16'hFFFF, 16'hFFFF);
    set_ops(2, 16'h0000, 16'h1234);
    set_ops(3, 16'h0001, 16'hABCD);
    req = 4'b1111;
    run_op("rr0", 4'b0001, 2'd0, 32'd15,        4'b1111, 4'b1111);
    run_op("rr1", 4'b0010, 2'd1, 32'hFFFE0001,  4'b1111, 4'b1111);
    run_op("rr2", 4'b0100, 2'd2, 32'h00000000,  4'b1111, 4'b1111);
    run_op("rr3", 4'b1000, 2'd3, 32'h0000ABCD,  4'b1111, 4'b1111);
    run_op("rr4", 4'b0001, 2'd0, 32'd15,        4'b1111, 4'b1111);

    // Late request: req[2] rises mid-WAIT of requester 0
    set_ops(2, 16'h1000, 16'h0010);
    req = 4'b0001;
    run_op("late0", 4'b0001, 2'd0, 32'd15,       4'b0000, 4'b0100);
    run_op("late2", 4'b0100, 2'd2, 32'h00010000, 4'b0000, 4'b0000);

    // Reset in the middle of an operation
    req = 4'b0010;
    step();
    chk("abort_grant", 32'(grant), 32'b0010);
    req = 4'b0000;
    step(); step();
    chk("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    chk_zero("abort");
    rst = 1'b0;
    for (int c = 0; c < LAT + 3; c++) begin
      step();
      chk($sformatf("abort_no_valid%0d", c), 32'(rsp_valid), 32'd0);
    end
    req = 4'b1000;
    run_op("post_abort", 4'b1000, 2'd3, 32'h0000ABCD, 4'b0000, 4'b0000);

    // Fairness: two requesters held for 20 operations
    set_ops(0, 16'd2, 16'd3);
    set_ops(1, 16'd4, 16'd5);
    for (int i = 0; i < 4; i++) gcount[i] = 0;
    req = 4'b0011;
    for (int n = 0; n < 20; n++) begin
      if (n % 2 == 0)
        run_op($sformatf("fair%0d", n), 4'b0001, 2'd0, 32'd6, 4'b0011, 4'b0011);
      else
        run_op($sformatf("fair%0d", n), 4'b0010, 2'd1, 32'd20, 4'b0011, 4'b0011);
    end
    req = 4'b0000;
    chk("fair_count0", 32'(gcount[0]), 32'd10);
    chk("fair_count1", 32'(gcount[1]), 32'd10);
    chk("fair_count2", 32'(gcount[2]), 32'd0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dbns_mult_scheduler.md
DBNS_MULT_SCHEDULER -- requirements
Module: dbns_mult_scheduler

Interface
REQ-001 SHALL have parameter LAT, default 4: DBNS multiplier latency in cycles, from operands stable to REGC valid; legal range 1..15.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port req  input  4  per-requester multiply request, level; bit i = requester i.
REQ-005 SHALL have port op_a  input  64  requester A operands, packed; requester i uses bits [16i+15:16i].
REQ-006 SHALL have port op_b  input  64  requester B operands, packed like op_a.
REQ-007 SHALL have port grant  output  4  one-hot, one-cycle pulse accepting requester i.
REQ-008 SHALL have port REGA  output  16  operand A to multiplier.
REQ-009 SHALL have port REGB  output  16  operand B to multiplier.
REQ-010 SHALL have port REGC  input  32  product from multiplier.
REQ-011 SHALL have port rsp_valid  output  1  one-cycle pulse: rsp_data/rsp_id valid.
REQ-012 SHALL have port rsp_id  output  2  index of requester owning rsp_data.
REQ-013 SHALL have port rsp_data  output  32  unsigned 32-bit product.
REQ-014 SHALL have port busy  output  1  high whenever state != IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, DONE; one operation in flight, no pipelining.
REQ-016 IDLE, req != 0 at edge: SHALL select winner by round-robin from ptr (ptr, ptr+1, ... mod 4), register grant[win]=1, REGA/REGB <= winner's operands, rsp_id <= win, cnt <= 0, go WAIT.
REQ-017 IDLE, req == 0: SHALL stay IDLE, grant=0, REGA/REGB held.
REQ-018 ptr SHALL update to (win+1) mod 4 on every grant.
REQ-019 WAIT: cnt SHALL increment each cycle; at cnt == LAT-1, go DONE; grant SHALL be 0 after its single grant cycle.
REQ-020 REGA/REGB SHALL remain stable from the grant cycle through DONE.
REQ-021 DONE: SHALL register rsp_data <= REGC and assert rsp_valid for exactly the next cycle, then go IDLE.
REQ-022 Timing: grant high in cycle G; rsp_valid high in cycle G+LAT+1; earliest next grant is cycle G+LAT+2.
REQ-023 req SHALL be sampled only in IDLE; requests arriving during WAIT/DONE wait, are not lost while held, and no grant is issued in a rsp_valid cycle.
REQ-024 Requester SHALL hold req and operands until grant and drop req the cycle after grant; req still high at the next IDLE evaluation counts as a new request.
REQ-025 rsp_data SHALL hold its value between pulses; product is unsigned 16x16, with no truncation or saturation (0xFFFF*0xFFFF = 0xFFFE0001).
REQ-026 Out-of-range LAT is unsupported; the counter SHALL be 4 bits.

Reset
REQ-027 rst SHALL force: state IDLE, ptr 0, cnt 0, grant 0, REGA 0, REGB 0, rsp_valid 0, rsp_id 0, rsp_data 0, busy 0.
REQ-028 rst asserted in WAIT or DONE SHALL abort the operation, with no rsp_valid for it afterwards.
REQ-029 rst SHALL take priority over every transition; first grant possible at the first edge after rst deasserts.

Verification
REQ-030 Single op: LAT=4, req=0001, op_a[15:0]=op_b[15:0]=7890 -> grant=0001 one cycle, rsp_valid 5 cycles later, rsp_id=0, rsp_data=62252100.
REQ-031 Round-robin: req=1111 held, distinct operands -> grant order 0001,0010,0100,1000,0001; spacing LAT+2 cycles; each rsp_id matches.
REQ-032 Boundary operands: 0xFFFF*0xFFFF -> 0xFFFE0001; 0x0000*0x1234 -> 0x00000000; 1*0xABCD -> 0x0000ABCD.
REQ-033 Late request: req[2] rises mid-WAIT of requester 0 -> no grant until after rsp_valid; grant=0100 exactly LAT+2 cycles after first grant.
REQ-034 Reset mid-op: rst one cycle during WAIT -> all outputs 0, no rsp_valid; next req=1000 -> grant=1000 (ptr back at 0, so searches 0..3).
REQ-035 Fairness/starvation: req=0011 held for 20 ops -> grants alternate 0001/0010, each requester exactly 10.
